// File: rtl/iq_na_sweep_master_pkg.sv
// ============================================================================
// Module : iq_na_sweep_master_pkg
// Brief  : Shared types and constants for the network-analyzer sweep master:
//          FSM encodings, bus widths, sum-word layout and address helper.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package iq_na_sweep_master_pkg;

  localparam int BUS_AW        = 16;   // bus address width
  localparam int BUS_DW        = 32;   // bus data width
  localparam int BUSY_BIT      = 31;   // averaging-busy flag inside each sum word
  localparam int SPLIT_W       = 31;   // payload bits taken from each sum word
  localparam int NUM_SUM_WORDS = 4;    // I lo, I hi, Q lo, Q hi

  // Sweep sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_WR_FREQ  = 3'd2,
    ST_WAIT_GAP = 3'd3,
    ST_RD_SUM   = 3'd4,
    ST_OUT      = 3'd5,
    ST_DONE     = 3'd6
  } sweep_state_t;

  // Single-transaction engine states
  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_WAIT = 1'b1
  } txn_state_t;

  // Address of sum word k: words are laid out on a 4-byte stride from base.
  function automatic logic [BUS_AW-1:0] sum_word_addr(input logic [BUS_AW-1:0] base,
                                                      input logic [1:0]        k);
    return base + {{(BUS_AW-4){1'b0}}, k, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/iq_na_sweep_master_if.sv
// ============================================================================
// Module : iq_na_sweep_master_if
// Brief  : IQ-block register bus (addr/wen/ren/wdata/ack/rdata) with
//          initiator (master) and responder (slave) views.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface iq_na_sweep_master_if;
  import iq_na_sweep_master_pkg::*;

  logic [BUS_AW-1:0] addr;
  logic              wen;
  logic              ren;
  logic [BUS_DW-1:0] wdata;
  logic              ack;
  logic [BUS_DW-1:0] rdata;

  modport master (output addr, wen, ren, wdata, input  ack, rdata);
  modport slave  (input  addr, wen, ren, wdata, output ack, rdata);
endinterface

`default_nettype wire

// File: rtl/iq_na_sweep_master_na_bus_txn.sv
// ============================================================================
// Module : iq_na_sweep_master_na_bus_txn
// Brief  : Single outstanding bus transaction engine. Issues a one-cycle
//          strobe on request, holds address/data until ack, reports done
//          (with read data) or timeout back to the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module iq_na_sweep_master_na_bus_txn
  import iq_na_sweep_master_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64
) (
  input  wire logic              clk,
  input  wire logic              rst,
  // sequencer side
  input  wire logic              i_abort,
  input  wire logic              i_req,
  input  wire logic              i_we,
  input  wire logic [BUS_AW-1:0] i_addr,
  input  wire logic [BUS_DW-1:0] i_wdata,
  output      logic              o_done,
  output      logic              o_timeout,
  output      logic [BUS_DW-1:0] o_rdata,
  // bus side
  output      logic [BUS_AW-1:0] o_addr,
  output      logic              o_wen,
  output      logic              o_ren,
  output      logic [BUS_DW-1:0] o_wdata,
  input  wire logic              i_ack,
  input  wire logic [BUS_DW-1:0] i_rdata
);

  localparam int            CW        = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] C_TIMEOUT = CW'(ACK_TIMEOUT);

  txn_state_t        r_state;
  txn_state_t        w_next;
  logic [CW-1:0]     r_cnt;
  logic [BUS_AW-1:0] r_addr;
  logic [BUS_DW-1:0] r_wdata;
  logic              w_strobe;

  // A new strobe fires only from idle, so a held request never double-issues.
  assign w_strobe = (r_state == TX_IDLE) && i_req && !i_abort;

  // Next-state and handshake decode; the ack window is cycles 1..ACK_TIMEOUT after the strobe.
  always_comb begin
    w_next    = r_state;
    o_done    = 1'b0;
    o_timeout = 1'b0;
    case (r_state)
      TX_IDLE: if (w_strobe) w_next = TX_WAIT;
      TX_WAIT: begin
        if (i_ack) begin
          o_done = 1'b1;
          w_next = TX_IDLE;
        end else if (r_cnt == C_TIMEOUT) begin
          o_timeout = 1'b1;
          w_next    = TX_IDLE;
        end
      end
      default: w_next = TX_IDLE;
    endcase
    if (i_abort) begin
      w_next    = TX_IDLE;
      o_done    = 1'b0;
      o_timeout = 1'b0;
    end
  end

  // State register, wait counter and held address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_strobe) begin
        r_cnt   <= CW'(1);
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end else if (r_state == TX_WAIT) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Address/data come straight from the request in the strobe cycle, then from the hold registers.
  always_comb begin
    o_wen   = w_strobe && i_we;
    o_ren   = w_strobe && !i_we;
    o_addr  = '0;
    o_wdata = '0;
    if (r_state == TX_WAIT) begin
      o_addr  = r_addr;
      o_wdata = r_wdata;
    end else if (w_strobe) begin
      o_addr  = i_addr;
      o_wdata = i_wdata;
    end
  end

  // Read data is valid to the sequencer in the ack cycle, alongside o_done.
  assign o_rdata = i_rdata;

endmodule

`default_nettype wire

// File: rtl/iq_na_sweep_master.sv
// ============================================================================
// Module : iq_na_sweep_master
// Brief  : Network-analyzer sweep sequencer. For each point writes the
//          frequency word, polls the four I/Q sum words until not busy and
//          presents one 62-bit I/Q result with a valid/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module iq_na_sweep_master
  import iq_na_sweep_master_pkg::*;
#(
  parameter int          PHASEBITS   = 32,
  parameter int          NPTSBITS    = 16,
  parameter logic [15:0] FREQ_ADDR   = 16'h108,
  parameter logic [15:0] SUM_ADDR    = 16'h140,
  parameter int          ACK_TIMEOUT = 64,
  parameter int          POLL_GAP    = 16
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_i,
  input  wire logic                 start_i,
  input  wire logic                 abort_i,
  input  wire logic [PHASEBITS-1:0] cfg_f0_i,
  input  wire logic [PHASEBITS-1:0] cfg_df_i,
  input  wire logic [NPTSBITS-1:0]  cfg_npts_i,
  iq_na_sweep_master_if.master      bus,
  output      logic                 res_valid_o,
  input  wire logic                 res_ready_i,
  output      logic [61:0]          res_i_o,
  output      logic [61:0]          res_q_o,
  output      logic [NPTSBITS-1:0]  res_idx_o,
  output      logic                 busy_o,
  output      logic                 done_o,
  output      logic                 err_o
);

  localparam int                  GW         = $clog2(POLL_GAP + 1);
  localparam logic [GW-1:0]       C_GAP_LAST = GW'(POLL_GAP - 1);
  localparam logic [NPTSBITS-1:0] C_ONE      = NPTSBITS'(1);

  sweep_state_t          r_state;
  sweep_state_t          w_next;
  logic [PHASEBITS-1:0]  r_freq;
  logic [PHASEBITS-1:0]  r_df;
  logic [NPTSBITS-1:0]   r_npts;
  logic [NPTSBITS-1:0]   r_idx;
  logic [1:0]            r_k;
  logic [GW-1:0]         r_gap;
  logic [SPLIT_W-1:0]    r_w [NUM_SUM_WORDS];
  logic                  r_err;

  logic                  w_req;
  logic                  w_we;
  logic [BUS_AW-1:0]     w_addr;
  logic                  w_tx_done;
  logic                  w_tx_timeout;
  logic [BUS_DW-1:0]     w_rdata;
  logic [BUS_AW-1:0]     w_bus_addr;
  logic                  w_bus_wen;
  logic                  w_bus_ren;
  logic [BUS_DW-1:0]     w_bus_wdata;
  logic                  w_start;

  assign w_start = (r_state == ST_IDLE) && start_i && !abort_i;

  iq_na_sweep_master_na_bus_txn #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_txn (
    .clk       (clk_i),
    .rst       (rst_i),
    .i_abort   (abort_i),
    .i_req     (w_req),
    .i_we      (w_we),
    .i_addr    (w_addr),
    .i_wdata   (BUS_DW'(r_freq)),
    .o_done    (w_tx_done),
    .o_timeout (w_tx_timeout),
    .o_rdata   (w_rdata),
    .o_addr    (w_bus_addr),
    .o_wen     (w_bus_wen),
    .o_ren     (w_bus_ren),
    .o_wdata   (w_bus_wdata),
    .i_ack     (bus.ack),
    .i_rdata   (bus.rdata)
  );

  assign bus.addr  = w_bus_addr;
  assign bus.wen   = w_bus_wen;
  assign bus.ren   = w_bus_ren;
  assign bus.wdata = w_bus_wdata;

  // Sequencer next-state and bus request decode; timeout then abort override everything.
  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    w_we   = 1'b0;
    w_addr = '0;
    case (r_state)
      ST_IDLE:     if (start_i) w_next = ST_SETUP;
      ST_SETUP:    w_next = (r_npts == '0) ? ST_DONE : ST_WR_FREQ;
      ST_WR_FREQ: begin
        w_req  = 1'b1;
        w_we   = 1'b1;
        w_addr = FREQ_ADDR;
        if (w_tx_done) w_next = ST_WAIT_GAP;
      end
      ST_WAIT_GAP: if (r_gap == C_GAP_LAST) w_next = ST_RD_SUM;
      ST_RD_SUM: begin
        w_req  = 1'b1;
        w_addr = sum_word_addr(SUM_ADDR, r_k);
        if (w_tx_done) begin
          if (w_rdata[BUSY_BIT])  w_next = ST_WAIT_GAP;
          else if (r_k == 2'd3)   w_next = ST_OUT;
        end
      end
      ST_OUT: if (res_ready_i) w_next = (r_idx == r_npts - C_ONE) ? ST_DONE : ST_WR_FREQ;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
    if (w_tx_timeout) w_next = ST_IDLE;
    if (abort_i) begin
      w_next = ST_IDLE;
      w_req  = 1'b0;
    end
  end

  // State register plus sweep datapath: config latch, poll gap, sum words, point advance, error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_freq  <= '0;
      r_df    <= '0;
      r_npts  <= '0;
      r_idx   <= '0;
      r_k     <= '0;
      r_gap   <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < NUM_SUM_WORDS; i++) r_w[i] <= '0;
    end else begin
      r_state <= w_next;
      r_gap   <= (r_state == ST_WAIT_GAP) ? r_gap + GW'(1) : '0;
      if (!abort_i) begin
        if (w_start) begin
          r_freq <= cfg_f0_i;
          r_df   <= cfg_df_i;
          r_npts <= cfg_npts_i;
          r_idx  <= '0;
          r_k    <= '0;
          r_err  <= 1'b0;
        end
        // A busy word invalidates the whole pass; the next pass restarts at word 0.
        if (r_state == ST_RD_SUM && w_tx_done) begin
          r_w[r_k] <= w_rdata[SPLIT_W-1:0];
          r_k      <= w_rdata[BUSY_BIT] ? 2'd0 : r_k + 2'd1;
        end
        if (r_state == ST_OUT && res_ready_i) begin
          r_idx  <= r_idx + C_ONE;
          r_freq <= r_freq + r_df;
        end
        if (w_tx_timeout) r_err <= 1'b1;
      end
    end
  end

  assign res_valid_o = (r_state == ST_OUT);
  assign res_i_o     = {r_w[1], r_w[0]};
  assign res_q_o     = {r_w[3], r_w[2]};
  assign res_idx_o   = r_idx;
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = (r_state == ST_DONE);
  assign err_o       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_iq_na_sweep_master.sv
// ============================================================================
// Module : tb_iq_na_sweep_master
// Brief  : Directed self-checking bench for iq_na_sweep_master with a
//          one-cycle-ack responder model on the IQ register bus.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_iq_na_sweep_master;

  localparam int          PHASEBITS   = 32;
  localparam int          NPTSBITS    = 16;
  localparam logic [15:0] FREQ_ADDR   = 16'h108;
  localparam logic [15:0] SUM_ADDR    = 16'h140;
  localparam int          ACK_TIMEOUT = 64;
  localparam int          POLL_GAP    = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 abort;
  logic [PHASEBITS-1:0] cfg_f0;
  logic [PHASEBITS-1:0] cfg_df;
  logic [NPTSBITS-1:0]  cfg_npts;
  logic                 res_valid;
  logic                 res_ready;
  logic [61:0]          res_i;
  logic [61:0]          res_q;
  logic [NPTSBITS-1:0]  res_idx;
  logic                 busy;
  logic                 done;
  logic                 err;

  iq_na_sweep_master_if bus();

  iq_na_sweep_master #(
    .PHASEBITS   (PHASEBITS),
    .NPTSBITS    (NPTSBITS),
    .FREQ_ADDR   (FREQ_ADDR),
    .SUM_ADDR    (SUM_ADDR),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .POLL_GAP    (POLL_GAP)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .abort_i     (abort),
    .cfg_f0_i    (cfg_f0),
    .cfg_df_i    (cfg_df),
    .cfg_npts_i  (cfg_npts),
    .bus         (bus),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_i_o     (res_i),
    .res_q_o     (res_q),
    .res_idx_o   (res_idx),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Responder model configuration
  logic        m_clr   = 1'b0;
  logic        m_noack = 1'b0;
  int          m_busy_polls = 0;
  logic [31:0] m_words [4];

  // Observations collected by the model
  int                  busy_given, wr_n, rd_n, done_n, res_n;
  logic [31:0]         wr_log      [16];
  logic [15:0]         wr_addr_log [16];
  logic [15:0]         rd_addr_log [64];
  logic [NPTSBITS-1:0] idx_log     [16];
  logic [61:0]         resi_log    [16];

  // Responder: acks one cycle after each strobe, returns busy for the first m_busy_polls reads.
  always @(posedge clk) begin
    bus.ack   <= 1'b0;
    bus.rdata <= 32'h0;
    if (m_clr) begin
      busy_given <= 0; wr_n <= 0; rd_n <= 0; done_n <= 0; res_n <= 0;
    end else begin
      if ((bus.wen || bus.ren) && !m_noack) begin
        bus.ack <= 1'b1;
        if (bus.ren) begin
          if (busy_given < m_busy_polls) begin
            bus.rdata  <= 32'h8000_0000;
            busy_given <= busy_given + 1;
          end else begin
            bus.rdata <= m_words[bus.addr[3:2]];
          end
        end
      end
      if (bus.wen) begin
        if (wr_n < 16) begin wr_log[wr_n] <= bus.wdata; wr_addr_log[wr_n] <= bus.addr; end
        wr_n <= wr_n + 1;
      end
      if (bus.ren) begin
        if (rd_n < 64) rd_addr_log[rd_n] <= bus.addr;
        rd_n <= rd_n + 1;
      end
      if (done) done_n <= done_n + 1;
      if (res_valid && res_ready) begin
        if (res_n < 16) begin idx_log[res_n] <= res_idx; resi_log[res_n] <= res_i; end
        res_n <= res_n + 1;
      end
    end
  end

  task automatic clear_model();
    m_clr = 1'b1;
    @(posedge clk); #1;
    m_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin @(posedge clk); #1; n++; end
    if (busy) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    cfg_f0 = '0; cfg_df = '0; cfg_npts = '0;
    m_words[0] = 32'h0; m_words[1] = 32'h0; m_words[2] = 32'h0; m_words[3] = 32'h0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0)       begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    checks++; if ({bus.wen, bus.ren} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {bus.wen, bus.ren}); end
    checks++; if (bus.addr !== 16'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0000", bus.addr); end
    checks++; if (res_i !== 62'h0)    begin failures++; $display("FAIL reset_res_i got=%h exp=0", res_i); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_sweep();
    int n;
    logic [31:0] exp_w [3];
    logic [15:0] exp_ra [4];
    exp_w[0] = 32'h1000; exp_w[1] = 32'h1100; exp_w[2] = 32'h1200;
    exp_ra[0] = 16'h140; exp_ra[1] = 16'h144; exp_ra[2] = 16'h148; exp_ra[3] = 16'h14C;
    m_words[0] = 32'h1234_5678; m_words[1] = 32'h0000_0ABC;
    m_words[2] = 32'h0000_0001; m_words[3] = 32'h4000_0000;
    m_busy_polls = 0; m_noack = 1'b0; res_ready = 1'b1;
    clear_model();
    cfg_f0 = 32'h1000; cfg_df = 32'h100; cfg_npts = 16'd3;
    pulse_start();
    wait_idle(400, n);
    checks++; if (n < 0) begin failures++; $display("FAIL basic_finish got=busy exp=idle within 400"); end
    checks++; if (wr_n !== 3) begin failures++; $display("FAIL basic_wr_count got=%0d exp=3", wr_n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (wr_log[i] !== exp_w[i]) begin failures++; $display("FAIL basic_wdata[%0d] got=%h exp=%h", i, wr_log[i], exp_w[i]); end
      checks++; if (idx_log[i] !== NPTSBITS'(i)) begin failures++; $display("FAIL basic_idx[%0d] got=%0d exp=%0d", i, idx_log[i], i); end
    end
    checks++; if (wr_addr_log[0] !== 16'h108) begin failures++; $display("FAIL basic_waddr got=%h exp=0108", wr_addr_log[0]); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (rd_addr_log[k] !== exp_ra[k]) begin failures++; $display("FAIL basic_raddr[%0d] got=%h exp=%h", k, rd_addr_log[k], exp_ra[k]); end
    end
    checks++; if (rd_n !== 12) begin failures++; $display("FAIL basic_rd_count got=%0d exp=12", rd_n); end
    checks++; if (resi_log[0] !== 62'h0000_055E_1234_5678) begin failures++; $display("FAIL basic_res_i got=%h exp=0000055e12345678", resi_log[0]); end
    checks++; if (res_q !== 62'h2000_0000_0000_0001) begin failures++; $display("FAIL basic_res_q got=%h exp=2000000000000001", res_q); end
    checks++; if (done_n !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_n); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", err); end
  endtask

  task automatic test_busy_poll();
    int n;
    m_words[0] = 32'h7FFF_FFFF; m_words[1] = 32'h0000_0001;
    m_words[2] = 32'h0; m_words[3] = 32'h0;
    m_busy_polls = 2; res_ready = 1'b1;
    clear_model();
    cfg_f0 = 32'h2000; cfg_df = 32'h10; cfg_npts = 16'd1;
    pulse_start();
    wait_idle(400, n);
    checks++; if (n < 0) begin failures++; $display("FAIL busy_finish got=busy exp=idle within 400"); end
    checks++; if (rd_n !== 6) begin failures++; $display("FAIL busy_rd_count got=%0d exp=6", rd_n); end
    checks++; if (resi_log[0] !== 62'h0000_0000_FFFF_FFFF) begin failures++; $display("FAIL busy_res_i got=%h exp=00000000ffffffff", resi_log[0]); end
    checks++; if (res_q !== 62'h0) begin failures++; $display("FAIL busy_res_q got=%h exp=0", res_q); end
    checks++; if (wr_n !== 1 || done_n !== 1) begin failures++; $display("FAIL busy_counts got wr=%0d done=%0d exp wr=1 done=1", wr_n, done_n); end
    m_busy_polls = 0;
  endtask

  task automatic test_timeout();
    int n;
    int cnt;
    m_noack = 1'b1;
    clear_model();
    cfg_f0 = 32'h3000; cfg_df = 32'h0; cfg_npts = 16'd1;
    pulse_start();
    n = 0;
    while (!bus.wen && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (bus.wen !== 1'b1) begin failures++; $display("FAIL tmo_strobe got=%b exp=1", bus.wen); end
    cnt = 0;
    while (!err && cnt < 200) begin @(posedge clk); #1; cnt++; end
    checks++; if (cnt !== ACK_TIMEOUT + 1) begin failures++; $display("FAIL tmo_latency got=%0d exp=%0d", cnt, ACK_TIMEOUT + 1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tmo_busy got=%b exp=0", busy); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done_n !== 0 || wr_n !== 1 || rd_n !== 0) begin failures++; $display("FAIL tmo_traffic got done=%0d wr=%0d rd=%0d exp 0/1/0", done_n, wr_n, rd_n); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%b exp=1", err); end
    m_noack = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    int unstable;
    int strobes;
    int wr0;
    int rd0;
    logic [61:0] si;
    logic [61:0] sq;
    logic [NPTSBITS-1:0] sidx;
    m_words[0] = 32'h0000_0005; m_words[1] = 32'h0000_0006;
    m_words[2] = 32'h0000_0007; m_words[3] = 32'h7FFF_FFFF;
    res_ready = 1'b0;
    clear_model();
    cfg_f0 = 32'h4000; cfg_df = 32'h40; cfg_npts = 16'd2;
    pulse_start();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL bp_err_clear got=%b exp=0", err); end
    n = 0;
    while (!res_valid && n < 200) begin @(posedge clk); #1; n++; end
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", res_valid); end
    si = res_i; sq = res_q; sidx = res_idx; wr0 = wr_n; rd0 = rd_n;
    unstable = 0; strobes = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || res_i !== si || res_q !== sq || res_idx !== sidx) unstable++;
      if (bus.wen || bus.ren) strobes++;
    end
    checks++; if (unstable !== 0) begin failures++; $display("FAIL bp_stable got=%0d unstable cycles exp=0", unstable); end
    checks++; if (strobes !== 0 || wr_n !== wr0 || rd_n !== rd0) begin failures++; $display("FAIL bp_no_strobe got=%0d strobes exp=0", strobes); end
    checks++; if (si !== 62'h0000_0003_0000_0005) begin failures++; $display("FAIL bp_res_i got=%h exp=0000000300000005", si); end
    checks++; if (sq !== 62'h3FFF_FFFF_8000_0007) begin failures++; $display("FAIL bp_res_q got=%h exp=3fffffff80000007", sq); end
    checks++; if (sidx !== 16'd0) begin failures++; $display("FAIL bp_idx got=%0d exp=0", sidx); end
    res_ready = 1'b1;
    wait_idle(400, n);
    checks++; if (n < 0 || done_n !== 1 || res_n !== 2) begin failures++; $display("FAIL bp_finish got n=%0d done=%0d res=%0d exp done=1 res=2", n, done_n, res_n); end
  endtask

  task automatic test_wrap_abort();
    int n;
    int rd_snap;
    res_ready = 1'b1;
    clear_model();
    cfg_f0 = 32'hFFFF_FF00; cfg_df = 32'h200; cfg_npts = 16'd2;
    pulse_start();
    n = 0;
    while (wr_n < 2 && n < 200) begin @(posedge clk); #1; n++; end
    checks++; if (wr_log[1] !== 32'h0000_0100) begin failures++; $display("FAIL wrap_wdata got=%h exp=00000100", wr_log[1]); end
    checks++; if (wr_log[0] !== 32'hFFFF_FF00) begin failures++; $display("FAIL wrap_first got=%h exp=ffffff00", wr_log[0]); end
    n = 0;
    while (!bus.ren && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL abort_idle got busy=%b valid=%b exp 0/0", busy, res_valid); end
    checks++; if ({bus.wen, bus.ren} !== 2'b00) begin failures++; $display("FAIL abort_strobes got=%b exp=00", {bus.wen, bus.ren}); end
    rd_snap = rd_n;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (done_n !== 0 || rd_n !== rd_snap || busy !== 1'b0) begin failures++; $display("FAIL abort_quiet got done=%0d rd=%0d busy=%b exp 0/%0d/0", done_n, rd_n, busy, rd_snap); end
    checks++; if (res_n !== 1 || err !== 1'b0) begin failures++; $display("FAIL abort_state got res=%0d err=%b exp 1/0", res_n, err); end
  endtask

  task automatic test_zero_points();
    int n;
    clear_model();
    cfg_f0 = 32'h5000; cfg_df = 32'h1; cfg_npts = 16'd0;
    pulse_start();
    n = 0;
    while (!done && n < 10) begin @(posedge clk); #1; n++; end
    checks++; if (done !== 1'b1 || n > 3) begin failures++; $display("FAIL zero_done got done=%b after %0d cycles exp 1 within 3", done, n); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wr_n !== 0 || rd_n !== 0 || busy !== 1'b0) begin failures++; $display("FAIL zero_traffic got wr=%0d rd=%0d busy=%b exp 0/0/0", wr_n, rd_n, busy); end
  endtask

  task automatic test_start_abort_same();
    clear_model();
    cfg_f0 = 32'h6000; cfg_df = 32'h1; cfg_npts = 16'd1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_abort_busy got=%b exp=0", busy); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (wr_n !== 0 || done_n !== 0) begin failures++; $display("FAIL start_abort_traffic got wr=%0d done=%0d exp 0/0", wr_n, done_n); end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_busy_poll();
    test_timeout();
    test_backpressure();
    test_wrap_abort();
    test_zero_points();
    test_start_abort_same();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
